multicycle_control32: RTL
=========================

Name: multicycle_control32

Overview:
- Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB per instruction for a shared-memory datapath.
- Decodes the same instruction subset as the single-cycle controller: R-type, jr, I-format ALU (Opcode[5:3]=001), lw, sw, beq, bne, j, jal.
- Adds parametrised memory latency with a ready handshake, an illegal-opcode policy, and a retired-instruction counter.
- Sits between the IR/ALU-flag outputs and the multi-cycle datapath muxes and enables.

Parameters:
- MEM_LAT, 1, minimum cycles each memory state is held (>=1).
- CNT_W, 32, retired-instruction counter width.
- TRAP_ILLEGAL, 1, 1: illegal opcode halts in S_ILLEGAL until reset; 0: treated as NOP.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Opcode  in  6  IR[31:26], stable from DECODE until the instruction's final state
- Function_opcode  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, valid in S_BRANCH
- mem_ready  in  1  memory completion handshake
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, IorD, ALUSrcA, Sftmd, Jrn, Jal  out  1 each
- PCSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 register (jr)
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-extended imm, 11 imm<<2
- ALUOp  out  2  00 add, 01 subtract/compare, 10 funct/opcode decode
- RegDST  out  2  00 rt, 01 rd, 10 r31
- instr_done  out  1  final cycle of an instruction
- illegal  out  1  S_ILLEGAL occupied
- retired  out  CNT_W  retired-instruction count
- state  out  4  current state, for debug

Behaviour:
- Reset is asynchronous and active-high.
- While reset=1:
  - state=S_FETCH(0), retired=0, wait counter=0.
  - All strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite), instr_done and illegal are forced to 0.
  - The first fetch begins in the first cycle after reset deasserts.
- Reset mid-instruction aborts it at once; no partial strobe occurs after reset asserts.
- Outputs are decoded from state only (Moore), except PCWrite in S_BRANCH and the completion strobes.
- Any output not listed for a state is 0.
- Encodings: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXECR6 RWB7 EXECI8 IWB9 BRANCH10 JUMP11 JAL12 JR13 ILLEGAL14.
- Memory states (FETCH, MEMRD, MEMWR):
  - Wait counter clears on entry and increments, saturating at MEM_LAT-1.
  - done_mem = (cnt==MEM_LAT-1) & mem_ready.
  - The state holds until done_mem, so the minimum occupancy is MEM_LAT cycles.
  - If mem_ready stays low, the state holds indefinitely.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=done_mem, i.e. a single-cycle pulse.
  - Goes to DECODE on done_mem.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by priority:
    - Opcode 100011 or 101011 -> MEMADR.
    - Opcode 000000 with Function_opcode 001000 -> JR.
    - Opcode 000000 otherwise -> EXECR.
    - Opcode[5:3]=001 -> EXECI.
    - 000100 or 000101 -> BRANCH.
    - 000010 -> JUMP.
    - 000011 -> JAL.
    - Anything else -> ILLEGAL if TRAP_ILLEGAL=1; otherwise FETCH with instr_done=1 (NOP).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on done_mem.
- MEMWB: RegWrite=1, MemtoReg=1, RegDST=00, instr_done=1. Goes to FETCH.
- MEMWR:
  - MemWrite=1, IorD=1, held for the whole state.
  - instr_done=done_mem.
  - Goes to FETCH on done_mem.
- EXECR: ALUSrcA=1, ALUSrcB=00, ALUOp=10, Sftmd=(Function_opcode[5:3]==000). Goes to RWB.
- RWB: RegWrite=1, RegDST=01, instr_done=1. Goes to FETCH.
- EXECI: ALUSrcA=1, ALUSrcB=10, ALUOp=10. Goes to IWB.
- IWB: RegWrite=1, RegDST=00, instr_done=1. Goes to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, instr_done=1.
  - PCWrite = (Opcode==000100 & Zero) | (Opcode==000101 & ~Zero).
  - Goes to FETCH.
- JUMP: PCWrite=1, PCSrc=10, instr_done=1. Goes to FETCH.
- JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDST=10, Jal=1, instr_done=1. Goes to FETCH.
- JR: PCWrite=1, PCSrc=11, Jrn=1, instr_done=1. Goes to FETCH.
- ILLEGAL: illegal=1, all strobes 0. Stays in ILLEGAL until reset.
- retired:
  - Increments on each rising edge where instr_done=1.
  - Wraps from 2^CNT_W-1 to 0.
  - Not incremented in ILLEGAL.
- Cycle counts with MEM_LAT=1 and mem_ready=1:
  - lw 5, sw 4, R/I 4.
  - beq/bne/j/jal/jr 3.
  - Each memory state adds MEM_LAT-1 cycles.

Test Plan:
- Reset, then R-type add (Op 000000, Fn 100000), MEM_LAT=1 -> states 0,1,6,7,0; RegWrite=1 and RegDST=01 only in cycle 4; retired=1.
- lw with MEM_LAT=3, mem_ready high -> FETCH 3 cycles, MEMRD 3 cycles, 9 cycles total; IRWrite is one pulse, in FETCH cycle 3.
- sw with mem_ready held low 5 cycles in MEMWR -> MemWrite stays 1 throughout; instr_done and the FETCH transition occur only in the cycle mem_ready=1.
- beq with Zero=1, then beq with Zero=0, then bne with Zero=0 -> PCWrite in BRANCH is 1, 0, 1; each instruction takes 3 cycles.
- Opcode 111111 with TRAP_ILLEGAL=1 -> state=14, illegal=1 indefinitely, retired unchanged; assert reset -> state=0 asynchronously. Repeat with TRAP_ILLEGAL=0 -> NOP, retired+1.
- CNT_W=4, retire 17 jal instructions -> retired=1 after wrap; RegDST=10, Jal=1 and PCSrc=10 in JAL. Assert reset mid-MEMRD -> MemRead drops before the next edge.

Source files
------------

// File: rtl/multicycle_control32_if.sv
// Control-unit bus for the multi-cycle MIPS datapath.
// Inputs to the controller: IR fields, ALU Zero flag and memory ready handshake.
// Outputs: datapath mux selects, write enables, completion/illegal flags,
// the retired-instruction count and the current state for debug.
// master: the controller side.  slave: the datapath/environment side.
interface multicycle_control32_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Opcode;
  logic [5:0]       Function_opcode;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic             MemtoReg, IorD, ALUSrcA, Sftmd, Jrn, Jal;
  logic [1:0]       PCSrc, ALUSrcB, ALUOp, RegDST;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport master (
    input  Opcode, Function_opcode, Zero, mem_ready,
    output PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
           MemtoReg, IorD, ALUSrcA, Sftmd, Jrn, Jal,
           PCSrc, ALUSrcB, ALUOp, RegDST,
           instr_done, illegal, retired, state
  );

  modport slave (
    output Opcode, Function_opcode, Zero, mem_ready,
    input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
           MemtoReg, IorD, ALUSrcA, Sftmd, Jrn, Jal,
           PCSrc, ALUSrcB, ALUOp, RegDST,
           instr_done, illegal, retired, state
  );
endinterface

// File: rtl/multicycle_control32.sv
// Multi-cycle MIPS control unit: Moore FSM stepping FETCH/DECODE/EXEC/MEM/WB
// for a shared-memory datapath, with a configurable memory latency plus ready
// handshake, an illegal-opcode trap and a retired-instruction counter.
// Ports: clock, reset (async, active-high), bus (control interface, master).
module multicycle_control32 #(
  parameter int MEM_LAT      = 1,
  parameter int CNT_W        = 32,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  multicycle_control32_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR  = 4'd6,  S_RWB    = 4'd7,
    S_EXECI  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13, S_ILLEGAL = 4'd14
  } state_t;

  localparam int          CW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             is_mem, done_mem;
  logic             pc_write, ir_write, mem_read, mem_write, reg_write, done, ill;

  assign is_mem   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign done_mem = (wait_cnt == LAT_M1) && bus.mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Cleared on every state change so each memory state starts a fresh count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                wait_cnt <= '0;
    else if (state_d != state_q)              wait_cnt <= '0;
    else if (is_mem && (wait_cnt != LAT_M1))  wait_cnt <= wait_cnt + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     retired_q <= '0;
    else if (done) retired_q <= retired_q + CNT_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    done          = 1'b0;
    ill           = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.IorD      = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.Sftmd     = 1'b0;
    bus.Jrn       = 1'b0;
    bus.Jal       = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ALUOp     = 2'b00;
    bus.RegDST    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        bus.ALUSrcB = 2'b01;
        pc_write    = done_mem;
        ir_write    = done_mem;
        if (done_mem) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        if (bus.Opcode == 6'b100011 || bus.Opcode == 6'b101011) state_d = S_MEMADR;
        else if (bus.Opcode == 6'b000000)
          state_d = (bus.Function_opcode == 6'b001000) ? S_JR : S_EXECR;
        else if (bus.Opcode[5:3] == 3'b001)                     state_d = S_EXECI;
        else if (bus.Opcode == 6'b000100 || bus.Opcode == 6'b000101) state_d = S_BRANCH;
        else if (bus.Opcode == 6'b000010)                       state_d = S_JUMP;
        else if (bus.Opcode == 6'b000011)                       state_d = S_JAL;
        else if (TRAP_ILLEGAL)                                  state_d = S_ILLEGAL;
        else begin
          // Unknown opcode retires as a NOP straight from decode.
          state_d = S_FETCH;
          done    = 1'b1;
        end
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = bus.Opcode[3] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        bus.IorD = 1'b1;
        if (done_mem) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write    = 1'b1;
        bus.MemtoReg = 1'b1;
        done         = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        bus.IorD  = 1'b1;
        done      = done_mem;
        if (done_mem) state_d = S_FETCH;
      end
      S_EXECR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
        bus.Sftmd   = (bus.Function_opcode[5:3] == 3'b000);
        state_d     = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        bus.RegDST = 2'b01;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECI: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = 2'b10;
        state_d     = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b01;
        bus.PCSrc   = 2'b01;
        pc_write    = ((bus.Opcode == 6'b000100) &&  bus.Zero) ||
                      ((bus.Opcode == 6'b000101) && !bus.Zero);
        done        = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        bus.PCSrc = 2'b10;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        bus.PCSrc  = 2'b10;
        reg_write  = 1'b1;
        bus.RegDST = 2'b10;
        bus.Jal    = 1'b1;
        done       = 1'b1;
        state_d    = S_FETCH;
      end
      S_JR: begin
        pc_write  = 1'b1;
        bus.PCSrc = 2'b11;
        bus.Jrn   = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: ill = 1'b1;
      default:   state_d = S_FETCH;
    endcase
  end

  // Reset masks strobes combinationally so nothing fires while it is held.
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.MemRead    = mem_read  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.instr_done = done      & ~reset;
  assign bus.illegal    = ill       & ~reset;
  assign bus.retired    = retired_q;
  assign bus.state      = state_q;
endmodule
